// File: rtl/player_motion_ctrl.sv
// Fighter sprite movement controller: buttons in, position/facing/movement state out,
// advanced once per frame_tick with gravity, air jumps, run detection, clamping and respawn.
module player_motion_ctrl #(
    parameter int WIDTH         = 16,
    parameter int HEIGHT        = 16,
    parameter int INITIAL_X     = 100,
    parameter int INITIAL_Y     = 378,
    parameter int SCREEN_W      = 640,
    parameter int KILL_Y        = 480,
    parameter int PLATFORM_Y    = 410,
    parameter int PLAT_X_MIN    = 20,
    parameter int PLAT_X_MAX    = 600,
    parameter int WALK_VEL      = 3,
    parameter int RUN_VEL       = 6,
    parameter int JUMP_VEL      = -12,
    parameter int MAX_FALL      = 10,
    parameter int GRAVITY_DIV   = 2,
    parameter int MAX_AIR_JUMPS = 1,
    parameter int RUN_WINDOW    = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       facing_right,
    output logic [2:0] move_state,
    output logic       airborne,
    output logic       respawn_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WALK   = 3'd1,
        ST_RUN    = 3'd2,
        ST_CROUCH = 3'd3,
        ST_JUMP   = 3'd4,
        ST_FALL   = 3'd5
    } move_state_t;

    localparam logic signed [12:0] C_SPRITE_H  = 13'(2 * HEIGHT);
    localparam logic signed [12:0] C_PLAT_Y    = 13'(PLATFORM_Y);
    localparam logic signed [12:0] C_PLAT_XMIN = 13'(PLAT_X_MIN);
    localparam logic signed [12:0] C_PLAT_XMAX = 13'(PLAT_X_MAX);
    localparam logic signed [12:0] C_X_MAX     = 13'(SCREEN_W - 2 * WIDTH);
    localparam logic signed [12:0] C_KILL_Y    = 13'(KILL_Y);
    localparam logic signed [12:0] C_INIT_X    = 13'(INITIAL_X);
    localparam logic signed [12:0] C_INIT_Y    = 13'(INITIAL_Y);
    localparam logic signed [12:0] C_WALK      = 13'(WALK_VEL);
    localparam logic signed [12:0] C_RUN       = 13'(RUN_VEL);
    localparam logic signed [12:0] C_JUMP      = 13'(JUMP_VEL);
    localparam logic signed [12:0] C_MAX_FALL  = 13'(MAX_FALL);
    localparam logic [7:0]         C_GRAV_LAST = 8'(GRAVITY_DIV - 1);
    localparam logic [7:0]         C_RUN_WIN   = 8'(RUN_WINDOW);
    localparam logic [2:0]         C_AIR_JUMPS = 3'(MAX_AIR_JUMPS);
    localparam logic [9:0]         X_RST       = 10'(INITIAL_X);
    localparam logic signed [10:0] Y_RST       = 11'(INITIAL_Y);

    logic [9:0]         x_q, x_d;
    logic signed [10:0] y_q, y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [7:0]         grav_cnt_q, grav_cnt_d;
    logic [2:0]         jumps_left_q, jumps_left_d;
    logic               run_latch_q, run_latch_d;
    logic [7:0]         run_timer_q, run_timer_d;
    logic               prev_up_q, prev_down_q, prev_left_q, prev_right_q;
    logic               facing_q, facing_d;
    move_state_t        state_q, state_d;
    logic               airborne_q, airborne_d;
    logic               respawn_pulse_q, respawn_pulse_d;

    logic signed [12:0] x_s, y_s, vel_s, foot_s;
    logic               grounded, in_air;
    logic               up_p, down_p, left_p, right_p;
    logic               move_left, move_right, moving;
    logic signed [12:0] speed, x_step, x_clamp;
    logic signed [12:0] vel_v, y_raw, foot_raw;
    logic [2:0]         jumps_v;
    logic               respawn, land;
    logic signed [12:0] x_n, y_n, vel_n;
    logic               grounded_n;
    logic               unused_hi_bits;

    assign x_s    = {3'b000, x_q};
    assign y_s    = {{2{y_q[10]}}, y_q};
    assign vel_s  = {{5{vel_q[7]}}, vel_q};
    assign foot_s = y_s + C_SPRITE_H;

    assign grounded = (foot_s == C_PLAT_Y) && (x_s >= C_PLAT_XMIN) && (x_s <= C_PLAT_XMAX)
                      && !vel_q[7];
    assign in_air   = ~grounded;

    assign up_p    = btn_up    & ~prev_up_q;
    assign down_p  = btn_down  & ~prev_down_q;
    assign left_p  = btn_left  & ~prev_left_q;
    assign right_p = btn_right & ~prev_right_q;

    // A second direction press inside the window latches run speed.
    always_comb begin
        run_timer_d = run_timer_q;
        run_latch_d = run_latch_q;
        if (run_timer_q != 8'd0) run_timer_d = run_timer_q - 8'd1;
        if ((left_p || right_p) && grounded) begin
            if (run_timer_q != 8'd0) begin
                run_latch_d = 1'b1;
                run_timer_d = 8'd0;
            end else begin
                run_timer_d = C_RUN_WIN;
            end
        end
        if (!btn_left && !btn_right) run_latch_d = 1'b0;
    end

    assign move_left  = btn_left & ~btn_right;
    assign move_right = btn_right & ~btn_left;
    assign moving     = move_left | move_right;
    assign speed      = run_latch_d ? C_RUN : C_WALK;

    always_comb begin
        x_step   = x_s;
        facing_d = facing_q;
        if (moving) begin
            facing_d = move_right;
            if (!(grounded && btn_down)) x_step = move_right ? (x_s + speed) : (x_s - speed);
        end
        if (x_step < 13'sd0)        x_clamp = 13'sd0;
        else if (x_step > C_X_MAX)  x_clamp = C_X_MAX;
        else                        x_clamp = x_step;
    end

    always_comb begin
        vel_v      = vel_s;
        grav_cnt_d = grav_cnt_q;
        jumps_v    = jumps_left_q;
        if (up_p && grounded) begin
            vel_v      = C_JUMP;
            grav_cnt_d = 8'd0;
        end else if (up_p && in_air && (jumps_left_q != 3'd0)) begin
            vel_v      = C_JUMP;
            jumps_v    = jumps_left_q - 3'd1;
            grav_cnt_d = 8'd0;
        end else if (down_p && in_air && !vel_q[7]) begin
            vel_v = C_MAX_FALL;
        end else if (in_air) begin
            if (grav_cnt_q == C_GRAV_LAST) begin
                grav_cnt_d = 8'd0;
                vel_v      = (vel_s >= C_MAX_FALL) ? C_MAX_FALL : (vel_s + 13'sd1);
            end else begin
                grav_cnt_d = grav_cnt_q + 8'd1;
            end
        end else begin
            vel_v      = 13'sd0;
            grav_cnt_d = 8'd0;
        end
    end

    assign y_raw    = y_s + vel_v;
    assign foot_raw = y_raw + C_SPRITE_H;
    assign respawn  = (y_raw >= C_KILL_Y);
    // Landing only from above: the foot must cross the surface moving downward.
    assign land     = !vel_v[12] && (x_clamp >= C_PLAT_XMIN) && (x_clamp <= C_PLAT_XMAX)
                      && (foot_s <= C_PLAT_Y) && (foot_raw >= C_PLAT_Y);

    always_comb begin
        x_n          = x_clamp;
        y_n          = y_raw;
        vel_n        = vel_v;
        jumps_left_d = jumps_v;
        if (respawn) begin
            x_n          = C_INIT_X;
            y_n          = C_INIT_Y;
            vel_n        = 13'sd0;
            jumps_left_d = C_AIR_JUMPS;
        end else begin
            if (land) begin
                y_n          = C_PLAT_Y - C_SPRITE_H;
                vel_n        = 13'sd0;
                jumps_left_d = C_AIR_JUMPS;
            end
            if (y_raw < 13'sd0) begin
                y_n   = 13'sd0;
                vel_n = 13'sd0;
            end
        end
    end

    assign grounded_n = ((y_n + C_SPRITE_H) == C_PLAT_Y) && (x_n >= C_PLAT_XMIN)
                        && (x_n <= C_PLAT_XMAX) && !vel_n[12];

    always_comb begin
        state_d = ST_FALL;
        if (grounded_n) begin
            if (btn_down)                  state_d = ST_CROUCH;
            else if (moving && run_latch_d) state_d = ST_RUN;
            else if (moving)               state_d = ST_WALK;
            else                           state_d = ST_IDLE;
        end else if (vel_n[12]) begin
            state_d = ST_JUMP;
        end
    end

    assign airborne_d      = ~grounded_n;
    assign respawn_pulse_d = frame_tick & respawn;
    assign x_d             = x_n[9:0];
    assign y_d             = y_n[10:0];
    assign vel_d           = vel_n[7:0];
    assign unused_hi_bits  = ^{x_n[12:10], y_n[12:11], vel_n[12:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q             <= X_RST;
            y_q             <= Y_RST;
            vel_q           <= 8'sd0;
            grav_cnt_q      <= 8'd0;
            jumps_left_q    <= C_AIR_JUMPS;
            run_latch_q     <= 1'b0;
            run_timer_q     <= 8'd0;
            prev_up_q       <= 1'b0;
            prev_down_q     <= 1'b0;
            prev_left_q     <= 1'b0;
            prev_right_q    <= 1'b0;
            facing_q        <= 1'b1;
            state_q         <= ST_FALL;
            airborne_q      <= 1'b1;
            respawn_pulse_q <= 1'b0;
        end else begin
            respawn_pulse_q <= respawn_pulse_d;
            if (frame_tick) begin
                x_q          <= x_d;
                y_q          <= y_d;
                vel_q        <= vel_d;
                grav_cnt_q   <= grav_cnt_d;
                jumps_left_q <= jumps_left_d;
                run_latch_q  <= run_latch_d;
                run_timer_q  <= run_timer_d;
                prev_up_q    <= btn_up;
                prev_down_q  <= btn_down;
                prev_left_q  <= btn_left;
                prev_right_q <= btn_right;
                facing_q     <= facing_d;
                state_q      <= state_d;
                airborne_q   <= airborne_d;
            end
        end
    end

    assign x_pos         = x_q;
    assign y_pos         = y_q[10] ? 10'd0 : y_q[9:0];
    assign facing_right  = facing_q;
    assign move_state    = state_q;
    assign airborne      = airborne_q;
    assign respawn_pulse = respawn_pulse_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: integer movement model checked every clock, plus
// directed button sequences with hand-computed positions.
module tb_player_motion_ctrl;

    localparam int P_W = 16, P_H = 16, P_IX = 100, P_IY = 378, P_SW = 640, P_KILL = 480;
    localparam int P_PY = 410, P_PXMIN = 20, P_PXMAX = 600, P_WALK = 3, P_RUN = 6;
    localparam int P_JUMP = -12, P_MAXF = 10, P_GDIV = 2, P_MAJ = 1, P_RWIN = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [9:0] x_pos, y_pos;
    logic       facing_right;
    logic [2:0] move_state;
    logic       airborne, respawn_pulse;

    int total = 0;
    int bad = 0;
    int n_tick = 0;

    // Model state, plain integers.
    int m_x, m_y, m_v, m_g, m_j, m_timer, m_state;
    bit m_latch, m_face, m_air, m_pulse, m_pu, m_pd, m_pl, m_pr;

    always #5 clk = ~clk;

    player_motion_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .facing_right (facing_right),
        .move_state   (move_state),
        .airborne     (airborne),
        .respawn_pulse(respawn_pulse)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit on_plat(input int x, input int y, input int v);
        return (y + 2 * P_H == P_PY) && (x >= P_PXMIN) && (x <= P_PXMAX) && (v >= 0);
    endfunction

    task automatic m_reset();
        m_x = P_IX; m_y = P_IY; m_v = 0; m_g = 0; m_j = P_MAJ; m_timer = 0;
        m_state = 5; m_latch = 0; m_face = 1; m_air = 1; m_pulse = 0;
        m_pu = 0; m_pd = 0; m_pl = 0; m_pr = 0;
    endtask

    task automatic m_step(input bit tk, input bit u, input bit d, input bit l, input bit r);
        bit up_p, dn_p, lp, rp, gnd, latch;
        int timer, dir, nx, ny, nv, ng, nj;
        if (!tk) begin
            m_pulse = 0;
            return;
        end
        up_p = u && !m_pu; dn_p = d && !m_pd; lp = l && !m_pl; rp = r && !m_pr;
        gnd = on_plat(m_x, m_y, m_v);
        timer = (m_timer > 0) ? m_timer - 1 : 0;
        latch = m_latch;
        if ((lp || rp) && gnd) begin
            if (m_timer != 0) begin latch = 1; timer = 0; end
            else timer = P_RWIN;
        end
        if (!l && !r) latch = 0;
        dir = int'(r) - int'(l);
        nx = m_x;
        if (dir != 0) begin
            m_face = (dir > 0);
            if (!(gnd && d)) nx = m_x + dir * (latch ? P_RUN : P_WALK);
        end
        if (nx < 0) nx = 0;
        if (nx > P_SW - 2 * P_W) nx = P_SW - 2 * P_W;
        nv = m_v; ng = m_g; nj = m_j;
        if (up_p && gnd) begin nv = P_JUMP; ng = 0; end
        else if (up_p && !gnd && m_j > 0) begin nv = P_JUMP; nj = m_j - 1; ng = 0; end
        else if (dn_p && !gnd && m_v >= 0) nv = P_MAXF;
        else if (!gnd) begin
            if (m_g == P_GDIV - 1) begin ng = 0; nv = (m_v + 1 > P_MAXF) ? P_MAXF : m_v + 1; end
            else ng = m_g + 1;
        end else begin nv = 0; ng = 0; end
        ny = m_y + nv;
        m_pulse = (ny >= P_KILL);
        if (m_pulse) begin
            nx = P_IX; ny = P_IY; nv = 0; nj = P_MAJ;
        end else begin
            if (nv >= 0 && nx >= P_PXMIN && nx <= P_PXMAX && m_y + 2 * P_H <= P_PY
                && ny + 2 * P_H >= P_PY) begin
                ny = P_PY - 2 * P_H; nv = 0; nj = P_MAJ;
            end
            if (ny < 0) begin ny = 0; nv = 0; end
        end
        gnd = on_plat(nx, ny, nv);
        m_air = !gnd;
        if (!gnd)          m_state = (nv < 0) ? 4 : 5;
        else if (d)        m_state = 3;
        else if (dir != 0) m_state = latch ? 2 : 1;
        else               m_state = 0;
        m_x = nx; m_y = ny; m_v = nv; m_g = ng; m_j = nj;
        m_latch = latch; m_timer = timer;
        m_pu = u; m_pd = d; m_pl = l; m_pr = r;
    endtask

    // Model advances on each rising edge; outputs compared on the falling edge.
    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (rst_n) m_step(frame_tick, btn_up, btn_down, btn_left, btn_right);
            @(negedge clk);
            if (!rst_n) m_reset();
            chk("model x", int'(x_pos), m_x);
            chk("model y", int'(y_pos), m_y);
            chk("model facing", int'(facing_right), int'(m_face));
            chk("model state", int'(move_state), m_state);
            chk("model airborne", int'(airborne), int'(m_air));
            chk("model pulse", int'(respawn_pulse), int'(m_pulse));
        end
    end

    task automatic do_tick(input bit u, input bit d, input bit l, input bit r);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        n_tick++;
        $display("tick %0d btn(udlr)=%b%b%b%b x=%0d y=%0d st=%0d air=%0b face=%0b pulse=%0b",
                 n_tick, u, d, l, r, x_pos, y_pos, move_state, airborne, facing_right,
                 respawn_pulse);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst x", int'(x_pos), 100);
        chk("rst y", int'(y_pos), 378);
        chk("rst state", int'(move_state), 5);
        chk("rst airborne", int'(airborne), 1);
        chk("rst facing", int'(facing_right), 1);
        chk("rst pulse", int'(respawn_pulse), 0);
        rst_n = 1'b1;

        do_tick(0, 0, 0, 0);
        chk("settle y", int'(y_pos), 378);
        chk("settle state", int'(move_state), 0);
        chk("settle airborne", int'(airborne), 0);
        chk("settle x", int'(x_pos), 100);

        // Ground jump, gravity every second tick, one air jump then a refused one.
        do_tick(1, 0, 0, 0);
        chk("jump y", int'(y_pos), 366);
        chk("jump state", int'(move_state), 4);
        do_tick(0, 0, 0, 0);
        chk("jump2 y", int'(y_pos), 354);
        do_tick(0, 0, 0, 0);
        chk("jump3 y", int'(y_pos), 343);
        do_tick(1, 0, 0, 0);
        chk("airjump y", int'(y_pos), 331);
        do_tick(0, 0, 0, 0);
        chk("airjump2 y", int'(y_pos), 319);
        do_tick(1, 0, 0, 0);
        chk("refused jump y", int'(y_pos), 308);
        for (int i = 0; i < 100 && airborne; i++) do_tick(0, 0, 0, 0);
        chk("land airborne", int'(airborne), 0);
        chk("land y", int'(y_pos), 378);
        chk("land state", int'(move_state), 0);

        // Air jump must be available again after landing.
        do_tick(1, 0, 0, 0);
        chk("rejump y", int'(y_pos), 366);
        do_tick(0, 0, 0, 0);
        chk("rejump2 y", int'(y_pos), 354);
        do_tick(1, 0, 0, 0);
        chk("restored airjump y", int'(y_pos), 342);
        for (int i = 0; i < 100 && airborne; i++) do_tick(0, 0, 0, 0);
        chk("land2 airborne", int'(airborne), 0);

        // Double-tap run detection.
        do_tick(0, 0, 0, 1);
        chk("walk x", int'(x_pos), 103);
        chk("walk state", int'(move_state), 1);
        do_tick(0, 0, 0, 0);
        chk("release x", int'(x_pos), 103);
        do_tick(0, 0, 0, 1);
        chk("run x", int'(x_pos), 109);
        chk("run state", int'(move_state), 2);
        do_tick(0, 0, 0, 1);
        chk("run hold x", int'(x_pos), 115);
        do_tick(0, 0, 0, 0);
        chk("idle state", int'(move_state), 0);
        do_tick(0, 0, 0, 1);
        chk("rewalk x", int'(x_pos), 118);
        chk("rewalk state", int'(move_state), 1);

        // Run off the right edge of the platform, then clamp at the screen edge.
        do_tick(0, 0, 0, 0);
        do_tick(0, 0, 0, 1);
        chk("run2 x", int'(x_pos), 124);
        for (int i = 0; i < 150 && !airborne; i++) do_tick(0, 0, 0, 1);
        chk("edge x", int'(x_pos), 604);
        chk("edge y", int'(y_pos), 378);
        chk("edge state", int'(move_state), 5);
        do_tick(0, 0, 0, 1);
        chk("clamp x", int'(x_pos), 608);
        do_tick(0, 0, 0, 1);
        chk("clamp hold x", int'(x_pos), 608);
        chk("clamp y", int'(y_pos), 379);

        // Fast-fall to the kill line and respawn.
        do_tick(0, 1, 0, 0);
        chk("fastfall y", int'(y_pos), 389);
        for (int i = 0; i < 50 && !respawn_pulse; i++) do_tick(0, 1, 0, 0);
        chk("respawn pulse", int'(respawn_pulse), 1);
        chk("respawn x", int'(x_pos), 100);
        chk("respawn y", int'(y_pos), 378);
        chk("respawn crouch", int'(move_state), 3);
        @(negedge clk);
        chk("pulse cleared", int'(respawn_pulse), 0);

        // Walk left off the platform and into the left screen edge.
        repeat (27) do_tick(0, 0, 1, 0);
        chk("falloff x", int'(x_pos), 19);
        chk("falloff state", int'(move_state), 5);
        chk("falloff airborne", int'(airborne), 1);
        chk("falloff facing", int'(facing_right), 0);
        repeat (7) do_tick(0, 0, 1, 0);
        chk("left clamp x", int'(x_pos), 0);
        do_tick(0, 0, 1, 0);
        chk("left clamp hold x", int'(x_pos), 0);

        // Reset in mid-fall takes effect without waiting for a clock edge.
        do_tick(0, 1, 0, 0);
        do_tick(0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset x", int'(x_pos), 100);
        chk("midreset y", int'(y_pos), 378);
        chk("midreset state", int'(move_state), 5);
        chk("midreset airborne", int'(airborne), 1);
        chk("midreset facing", int'(facing_right), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_tick(0, 0, 0, 0);
        chk("post reset state", int'(move_state), 0);
        chk("post reset airborne", int'(airborne), 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
